creg_file: RTL and testbench
============================

Name: creg_file

Overview:
- Control-register file and exception/mode controller for the CPU core.
- It answers the ID-stage creg read port (creg_rd_addr / creg_rd_data) and drives exe_mode.
- On the commit side it applies WRCR writes, takes exceptions and external interrupts, and executes EXRT (exception return).
- It issues the pipeline flush and redirect PC for exceptions and interrupts.

Parameters:
- IRQ_W, 8, number of external interrupt lines.
- RESET_VECTOR, 30'h0, word address loaded into the EXP_VECTOR register at reset.

Ports:
- clk  in  1  core clock
- reset_  in  1  asynchronous active-low reset
- creg_rd_addr  in  5  creg read address from the ID stage
- creg_rd_data  out  32  creg read data to the ID stage
- exe_mode  out  1  current mode: 0 = kernel (`CPU_KERNEL_MODE), 1 = user
- int_en  out  1  global interrupt enable (STATUS[1])
- wb_en  in  1  the committing instruction is valid
- wb_pc  in  30  word PC of the committing instruction
- wb_br_flag  in  1  the instruction before the committing one was a branch, so the committing instruction is a delay slot
- wb_ctrl_op  in  2  0 NOP, 1 WRCR, 2 EXRT
- wb_exp_code  in  3  exception code of the committing instruction; 0 = no exception
- wb_dst_addr  in  5  creg address targeted by WRCR
- wb_wr_data  in  32  WRCR write data
- stall  in  1  pipeline stalled; no commit this cycle
- irq  in  IRQ_W  asynchronous interrupt requests, active high, level sensitive
- flush  out  1  one-cycle flush of IF/ID/EX/MEM
- new_pc  out  30  redirect word address, valid while flush = 1

Behaviour:
- Register map, 32-bit each. Addresses 7..31 read 0 and ignore writes.
  - 0 STATUS {30'b0, ie, mode}
  - 1 PRE_STATUS {30'b0, ie, mode}
  - 2 INT_MASK [IRQ_W-1:0]; 1 = masked
  - 3 CAUSE {28'b0, dly, code[2:0]}
  - 4 EPC {epc[29:0], 2'b00}
  - 5 EXP_VECTOR {vec[29:0], 2'b00}
  - 6 IRQ_PEND, read-only: synchronized irq & ~INT_MASK
- Reset values (asynchronous, while reset_ = 0):
  - STATUS = 0: kernel mode, ie = 0.
  - PRE_STATUS = 0, INT_MASK = all 1s, CAUSE = 0, EPC = 0, EXP_VECTOR = RESET_VECTOR.
  - flush = 0, new_pc = 0, synchronizer flops = 0.
- irq path: two-flop synchronizer per line, so a change on irq is visible in IRQ_PEND after 2 clk edges.
- Read port:
  - creg_rd_data is combinational from creg_rd_addr.
  - Bypass: if a WRCR commits this cycle to the same address, return wb_wr_data. The write must qualify: wb_en = 1, stall = 0, no exception, and not pre-empted by an interrupt.
- Commit event: wb_en = 1 and stall = 0. With stall = 1, no register changes and flush = 0 next cycle.
- Priority per commit event, highest first:
  1. Exception: wb_exp_code != 0.
  2. Interrupt: ie = 1 and IRQ_PEND != 0; uses code 1 (EXT_INT).
  3. EXRT: wb_ctrl_op = 2.
  4. WRCR: wb_ctrl_op = 1.
- Exception and interrupt entry (same register update, next edge):
  - PRE_STATUS <= STATUS.
  - STATUS <= {ie = 0, mode = 0}.
  - CAUSE <= {dly = wb_br_flag, code}.
  - EPC <= wb_br_flag ? wb_pc - 1 : wb_pc; arithmetic is modulo 2^30.
  - The committing instruction is cancelled. For an interrupt it is not executed and is re-executed after EXRT; a WRCR pre-empted this way writes nothing.
- EXRT:
  - STATUS <= PRE_STATUS.
  - Redirect to EPC.
- Redirect timing: flush and new_pc are registered and appear the cycle after the commit event, for exactly one cycle.
  - Exception or interrupt: new_pc = EXP_VECTOR.
  - EXRT: new_pc = EPC.
- Consecutive commit events in the cycle when flush = 1 are ignored. The pipeline is being flushed and the instruction is a bubble.
- WRCR:
  - Writes wb_wr_data, masked to the field widths, into addresses 0..5.
  - Writes to addresses 6..31 are dropped.
- Codes 2..7 (UNDEF_INSN, OVERFLOW, MISA, TRAP, PRV_VIO, ...) are recorded verbatim in CAUSE.code. No code is special-cased.
- Reset mid-flush: flush drops immediately and asynchronously.

Test Plan:
- Reset release -> creg_rd_data at addr 5 = RESET_VECTOR<<2, exe_mode = 0, int_en = 0, flush = 0.
- WRCR addr 2 data 32'h0000_00FE, then WRCR addr 0 data 32'h2 (ie = 1, kernel), then irq[0] high -> after the 2-cycle sync and the next commit at wb_pc = 30'h100: flush = 1 one cycle; new_pc = EXP_VECTOR; CAUSE = 32'h1; EPC = 30'h100<<2; STATUS = 0; PRE_STATUS = 32'h2.
- wb_exp_code = 5 (TRAP), wb_br_flag = 1, wb_pc = 30'h40, user mode -> EPC = 30'h3F, CAUSE = 32'hD, exe_mode = 0.
- EXRT after that trap -> flush = 1 with new_pc = 30'h3F; exe_mode restored to 1.
- Same-cycle WRCR to addr 1 while creg_rd_addr = 1 -> creg_rd_data = wb_wr_data (bypass). With stall = 1 the same stimulus leaves PRE_STATUS unchanged and gives no bypass.
- Exception and pending interrupt on the same commit -> exception code recorded, not 1. irq masked (INT_MASK[0] = 1) -> no flush.

Source files
------------

// File: rtl/creg_file_if.sv
// Commit-side bus from the writeback stage into creg_file, and the redirect
// (flush / new_pc) it returns to the front of the pipeline.
interface creg_file_if;
  logic        wb_en;
  logic [29:0] wb_pc;
  logic        wb_br_flag;
  logic [1:0]  wb_ctrl_op;
  logic [2:0]  wb_exp_code;
  logic [4:0]  wb_dst_addr;
  logic [31:0] wb_wr_data;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;

  modport master (
    output wb_en, wb_pc, wb_br_flag, wb_ctrl_op, wb_exp_code,
    output wb_dst_addr, wb_wr_data, stall,
    input  flush, new_pc
  );

  modport slave (
    input  wb_en, wb_pc, wb_br_flag, wb_ctrl_op, wb_exp_code,
    input  wb_dst_addr, wb_wr_data, stall,
    output flush, new_pc
  );
endinterface

// File: rtl/creg_file.sv
// Control-register file and exception/mode controller: ID-stage creg read port,
// commit-side WRCR/EXRT handling, exception and interrupt entry with redirect.
module creg_file #(
  parameter int          IRQ_W        = 8,
  parameter logic [29:0] RESET_VECTOR = 30'h0
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [4:0]       creg_rd_addr,
  output logic [31:0]      creg_rd_data,
  output logic             exe_mode,
  output logic             int_en,
  input  logic [IRQ_W-1:0] irq,
  creg_file_if.slave       wb
);

  localparam logic [1:0] OP_WRCR    = 2'd1;
  localparam logic [1:0] OP_EXRT    = 2'd2;
  localparam logic [2:0] EXT_INT    = 3'd1;
  localparam logic [4:0] A_STATUS   = 5'd0;
  localparam logic [4:0] A_PRE_STAT = 5'd1;
  localparam logic [4:0] A_INT_MASK = 5'd2;
  localparam logic [4:0] A_CAUSE    = 5'd3;
  localparam logic [4:0] A_EPC      = 5'd4;
  localparam logic [4:0] A_EXP_VEC  = 5'd5;
  localparam logic [4:0] A_IRQ_PEND = 5'd6;

  logic [1:0]       status_q, status_d;
  logic [1:0]       pre_status_q, pre_status_d;
  logic [IRQ_W-1:0] int_mask_q, int_mask_d;
  logic [3:0]       cause_q, cause_d;
  logic [29:0]      epc_q, epc_d;
  logic [29:0]      vec_q, vec_d;
  logic [IRQ_W-1:0] irq_meta_q, irq_sync_q;
  logic             flush_q, flush_d;
  logic [29:0]      new_pc_q, new_pc_d;

  logic [IRQ_W-1:0] pend_s;
  logic             commit_s, irq_take_s, trap_s, exrt_s, wrcr_s;
  logic [2:0]       trap_code_s;
  logic [29:0]      trap_epc_s;
  logic [31:0]      mask_ext_s, pend_ext_s, rd_reg_s;

  // Commit qualification and priority: exception > interrupt > EXRT > WRCR.
  always_comb begin
    pend_s      = irq_sync_q & ~int_mask_q;
    commit_s    = wb.wb_en & ~wb.stall & ~flush_q;
    irq_take_s  = status_q[1] & (|pend_s);
    trap_s      = commit_s & ((wb.wb_exp_code != 3'd0) | irq_take_s);
    trap_code_s = (wb.wb_exp_code != 3'd0) ? wb.wb_exp_code : EXT_INT;
    trap_epc_s  = wb.wb_br_flag ? (wb.wb_pc - 30'd1) : wb.wb_pc;
    exrt_s      = commit_s & ~trap_s & (wb.wb_ctrl_op == OP_EXRT);
    wrcr_s      = commit_s & ~trap_s & (wb.wb_ctrl_op == OP_WRCR);
  end

  // Next-state for architectural registers and the registered redirect.
  always_comb begin
    status_d     = status_q;
    pre_status_d = pre_status_q;
    int_mask_d   = int_mask_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    vec_d        = vec_q;
    flush_d      = 1'b0;
    new_pc_d     = 30'h0;
    if (trap_s) begin
      pre_status_d = status_q;
      status_d     = 2'b00;
      cause_d      = {wb.wb_br_flag, trap_code_s};
      epc_d        = trap_epc_s;
      flush_d      = 1'b1;
      new_pc_d     = vec_q;
    end else if (exrt_s) begin
      status_d = pre_status_q;
      flush_d  = 1'b1;
      new_pc_d = epc_q;
    end else if (wrcr_s) begin
      case (wb.wb_dst_addr)
        A_STATUS:   status_d     = wb.wb_wr_data[1:0];
        A_PRE_STAT: pre_status_d = wb.wb_wr_data[1:0];
        A_INT_MASK: int_mask_d   = wb.wb_wr_data[IRQ_W-1:0];
        A_CAUSE:    cause_d      = wb.wb_wr_data[3:0];
        A_EPC:      epc_d        = wb.wb_wr_data[31:2];
        A_EXP_VEC:  vec_d        = wb.wb_wr_data[31:2];
        default:    status_d     = status_q;
      endcase
    end else begin
      flush_d = 1'b0;
    end
  end

  // Read mux; a qualifying same-cycle WRCR to a writable address is forwarded.
  always_comb begin
    mask_ext_s               = 32'h0;
    mask_ext_s[IRQ_W-1:0]    = int_mask_q;
    pend_ext_s               = 32'h0;
    pend_ext_s[IRQ_W-1:0]    = pend_s;
    case (creg_rd_addr)
      A_STATUS:   rd_reg_s = {30'h0, status_q};
      A_PRE_STAT: rd_reg_s = {30'h0, pre_status_q};
      A_INT_MASK: rd_reg_s = mask_ext_s;
      A_CAUSE:    rd_reg_s = {28'h0, cause_q};
      A_EPC:      rd_reg_s = {epc_q, 2'b00};
      A_EXP_VEC:  rd_reg_s = {vec_q, 2'b00};
      A_IRQ_PEND: rd_reg_s = pend_ext_s;
      default:    rd_reg_s = 32'h0;
    endcase
    if (wrcr_s && (wb.wb_dst_addr == creg_rd_addr) && (creg_rd_addr < A_IRQ_PEND)) begin
      creg_rd_data = wb.wb_wr_data;
    end else begin
      creg_rd_data = rd_reg_s;
    end
  end

  // Two-flop synchronizer for the asynchronous interrupt lines.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      irq_meta_q <= {IRQ_W{1'b0}};
      irq_sync_q <= {IRQ_W{1'b0}};
    end else begin
      irq_meta_q <= irq;
      irq_sync_q <= irq_meta_q;
    end
  end

  // Architectural state and redirect registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      status_q     <= 2'b00;
      pre_status_q <= 2'b00;
      int_mask_q   <= {IRQ_W{1'b1}};
      cause_q      <= 4'h0;
      epc_q        <= 30'h0;
      vec_q        <= RESET_VECTOR;
      flush_q      <= 1'b0;
      new_pc_q     <= 30'h0;
    end else begin
      status_q     <= status_d;
      pre_status_q <= pre_status_d;
      int_mask_q   <= int_mask_d;
      cause_q      <= cause_d;
      epc_q        <= epc_d;
      vec_q        <= vec_d;
      flush_q      <= flush_d;
      new_pc_q     <= new_pc_d;
    end
  end

  assign exe_mode  = status_q[0];
  assign int_en    = status_q[1];
  assign wb.flush  = flush_q;
  assign wb.new_pc = new_pc_q;

endmodule

// File: tb/tb_creg_file.sv
// Scoreboard bench for creg_file: stimulus pushes per-cycle expectations from a
// register-map reference model; a negedge monitor pops and compares.
module tb_creg_file;
  localparam int          IRQ_W = 8;
  localparam logic [29:0] RV    = 30'h0000_1234;

  logic             clk = 1'b0;
  logic             reset_ = 1'b0;
  logic [4:0]       creg_rd_addr;
  logic [31:0]      creg_rd_data;
  logic             exe_mode;
  logic             int_en;
  logic [IRQ_W-1:0] irq;

  creg_file_if bus();

  creg_file #(.IRQ_W(IRQ_W), .RESET_VECTOR(RV)) dut (
    .clk          (clk),
    .reset_       (reset_),
    .creg_rd_addr (creg_rd_addr),
    .creg_rd_data (creg_rd_data),
    .exe_mode     (exe_mode),
    .int_en       (int_en),
    .irq          (irq),
    .wb           (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic        mode;
    logic        ie;
    logic        fl;
    logic [29:0] npc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  // Reference model: register values as software would read them.
  logic [31:0]      m_reg [6];
  logic             m_flush;
  logic [29:0]      m_npc;
  logic [IRQ_W-1:0] h1, h2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] fmask(input int a);
    case (a)
      0, 1:    return 32'h0000_0003;
      2:       return (32'h1 << IRQ_W) - 32'h1;
      3:       return 32'h0000_000F;
      4, 5:    return 32'hFFFF_FFFC;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_reg[0] = 32'h0;
    m_reg[1] = 32'h0;
    m_reg[2] = fmask(2);
    m_reg[3] = 32'h0;
    m_reg[4] = 32'h0;
    m_reg[5] = {RV, 2'b00};
    m_flush  = 1'b0;
    m_npc    = 30'h0;
    h1       = '0;
    h2       = '0;
  endtask

  // One cycle: apply inputs, predict this cycle's outputs, advance the model.
  task automatic drive(input logic en, input logic st, input logic [1:0] op, input logic [2:0] ec,
                       input logic [4:0] dst, input logic [31:0] d, input logic [29:0] pc,
                       input logic br, input logic [IRQ_W-1:0] iq, input logic [4:0] ra);
    exp_t             e;
    logic [IRQ_W-1:0] pend;
    logic             commit, take;
    logic [31:0]      rd;
    logic [29:0]      ep;
    bus.wb_en = en; bus.stall = st; bus.wb_ctrl_op = op; bus.wb_exp_code = ec;
    bus.wb_dst_addr = dst; bus.wb_wr_data = d; bus.wb_pc = pc; bus.wb_br_flag = br;
    irq = iq; creg_rd_addr = ra;
    pend   = h2 & ~m_reg[2][IRQ_W-1:0];
    commit = en && !st && !m_flush;
    take   = commit && ((ec != 3'd0) || (m_reg[0][1] && (pend != '0)));
    if (ra < 5'd6)       rd = m_reg[ra];
    else if (ra == 5'd6) rd = 32'(pend);
    else                 rd = 32'h0;
    if (commit && !take && op == 2'd1 && dst == ra && dst < 5'd6) rd = d;
    e.rd = rd; e.mode = m_reg[0][0]; e.ie = m_reg[0][1]; e.fl = m_flush; e.npc = m_npc;
    if (chk_en) exp_q.push_back(e);
    m_flush = 1'b0;
    m_npc   = 30'h0;
    if (take) begin
      ep       = br ? pc - 30'd1 : pc;
      m_reg[1] = m_reg[0];
      m_reg[0] = 32'h0;
      m_reg[3] = {28'h0, br, (ec != 3'd0) ? ec : 3'd1};
      m_reg[4] = {ep, 2'b00};
      m_flush  = 1'b1;
      m_npc    = m_reg[5][31:2];
    end else if (commit && op == 2'd2) begin
      m_reg[0] = m_reg[1];
      m_flush  = 1'b1;
      m_npc    = m_reg[4][31:2];
    end else if (commit && op == 2'd1 && dst < 5'd6) begin
      m_reg[dst] = d & fmask(int'(dst));
    end
    h2 = h1;
    h1 = iq;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [IRQ_W-1:0] iq, input logic [4:0] ra);
    drive(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 30'h0, 1'b0, iq, ra);
  endtask

  // Monitor: every checked cycle the DUT outputs are compared with the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", creg_rd_data, e.rd);
        check("exe_mode", {31'h0, exe_mode}, {31'h0, e.mode});
        check("int_en", {31'h0, int_en}, {31'h0, e.ie});
        check("flush", {31'h0, bus.flush}, {31'h0, e.fl});
        if (e.fl) check("new_pc", {2'b00, bus.new_pc}, {2'b00, e.npc});
      end
    end
  end

  initial begin
    logic [2:0]       r_ec;
    logic [4:0]       r_dst, r_ra;
    logic [IRQ_W-1:0] r_irq;
    bus.wb_en = 1'b0; bus.stall = 1'b0; bus.wb_ctrl_op = 2'd0; bus.wb_exp_code = 3'd0;
    bus.wb_dst_addr = 5'd0; bus.wb_wr_data = 32'h0; bus.wb_pc = 30'h0; bus.wb_br_flag = 1'b0;
    irq = '0; creg_rd_addr = 5'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_ = 1'b1;
    chk_en = 1'b1;

    // Reset state and vector.
    idle('0, 5'd5);
    idle('0, 5'd2);

    // Unmask irq0, enable interrupts in kernel mode, raise irq0, commit at 0x100.
    drive(1'b1, 1'b0, 2'd1, 3'd0, 5'd2, 32'h0000_00FE, 30'h10, 1'b0, '0, 5'd2);
    drive(1'b1, 1'b0, 2'd1, 3'd0, 5'd0, 32'h0000_0002, 30'h11, 1'b0, '0, 5'd0);
    idle(8'h01, 5'd6);
    idle(8'h01, 5'd6);
    idle(8'h01, 5'd6);
    drive(1'b1, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 30'h100, 1'b0, 8'h01, 5'd3);
    drive(1'b1, 1'b0, 2'd1, 3'd0, 5'd2, 32'h0, 30'h101, 1'b0, '0, 5'd3);
    idle('0, 5'd4);
    idle('0, 5'd0);
    idle('0, 5'd1);

    // TRAP in a delay slot from user mode, then EXRT.
    drive(1'b1, 1'b0, 2'd1, 3'd0, 5'd0, 32'h0000_0001, 30'h20, 1'b0, '0, 5'd0);
    drive(1'b1, 1'b0, 2'd0, 3'd5, 5'd0, 32'h0, 30'h40, 1'b1, '0, 5'd0);
    idle('0, 5'd4);
    idle('0, 5'd3);
    drive(1'b1, 1'b0, 2'd2, 3'd0, 5'd0, 32'h0, 30'h50, 1'b0, '0, 5'd0);
    idle('0, 5'd0);
    idle('0, 5'd0);

    // Bypass, then the same stimulus under stall.
    drive(1'b1, 1'b0, 2'd1, 3'd0, 5'd1, 32'hDEAD_BEEF, 30'h60, 1'b0, '0, 5'd1);
    idle('0, 5'd1);
    drive(1'b1, 1'b1, 2'd1, 3'd0, 5'd1, 32'h1234_5670, 30'h61, 1'b0, '0, 5'd1);
    idle('0, 5'd1);

    // Exception and pending interrupt on the same commit.
    drive(1'b1, 1'b0, 2'd1, 3'd0, 5'd2, 32'h0000_00FE, 30'h70, 1'b0, '0, 5'd2);
    drive(1'b1, 1'b0, 2'd1, 3'd0, 5'd0, 32'h0000_0002, 30'h71, 1'b0, 8'h01, 5'd0);
    idle(8'h01, 5'd6);
    idle(8'h01, 5'd6);
    drive(1'b1, 1'b0, 2'd0, 3'd3, 5'd0, 32'h0, 30'h72, 1'b0, 8'h01, 5'd3);
    idle(8'h01, 5'd3);

    // Masked irq0 with ie = 1: commits must not flush.
    drive(1'b1, 1'b0, 2'd1, 3'd0, 5'd2, 32'h0000_00FF, 30'h80, 1'b0, 8'h01, 5'd6);
    drive(1'b1, 1'b0, 2'd1, 3'd0, 5'd0, 32'h0000_0002, 30'h81, 1'b0, 8'h01, 5'd6);
    drive(1'b1, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 30'h82, 1'b0, 8'h01, 5'd6);
    drive(1'b1, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 30'h83, 1'b0, 8'h01, 5'd6);
    idle('0, 5'd0);

    // Randomized traffic.
    r_irq = '0;
    for (int i = 0; i < 600; i++) begin
      r_ec  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if ($urandom_range(0, 11) == 0) r_irq = IRQ_W'($urandom);
      r_dst = 5'($urandom_range(0, 7));
      r_ra  = ($urandom_range(0, 1) == 1) ? r_dst : 5'($urandom_range(0, 31));
      if (r_dst >= 5'd6 && r_ra == r_dst) r_ra = 5'd4;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), r_ec,
            r_dst, $urandom, 30'($urandom), 1'($urandom_range(0, 1)), r_irq, r_ra);
    end
    idle('0, 5'd0);
    idle('0, 5'd0);
    chk_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    // Reset asserted during a flush cycle drops flush immediately.
    drive(1'b1, 1'b0, 2'd0, 3'd2, 5'd0, 32'h0, 30'h55, 1'b0, '0, 5'd5);
    check("flush_before_reset", {31'h0, bus.flush}, {31'h0, m_flush});
    check("new_pc_before_reset", {2'b00, bus.new_pc}, {2'b00, m_npc});
    reset_ = 1'b0;
    #1;
    check("flush_async_reset", {31'h0, bus.flush}, 32'h0);
    check("mode_async_reset", {31'h0, exe_mode}, 32'h0);
    check("vec_async_reset", creg_rd_data, {RV, 2'b00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
